// File: rtl/pm_bank_norm.sv
// rtl/pm_bank_norm.sv - ping-pong path-metric store with per-step min normalisation
// Reads come from the previous bank; ACS lanes write the current bank.
module pm_bank_norm #(
    parameter int K  = 5,
    parameter int M  = K - 1,
    parameter int S  = 1 << M,
    parameter int P  = 2,
    parameter int Wm = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_frame,
    input  logic                init_mode,
    input  logic [M-1:0]        init_state,
    input  logic                norm_en,
    input  logic [2*P*M-1:0]    rd_idx,
    output logic [2*P*Wm-1:0]   rd_pm,
    input  logic [P-1:0]        wr_en,
    input  logic [P*M-1:0]      wr_idx,
    input  logic [P*Wm-1:0]     wr_pm,
    input  logic                swap_banks,
    output logic                prev_A,
    output logic [Wm-1:0]       step_min,
    output logic [15:0]         step_cnt,
    output logic                err_incomplete,
    output logic                err_collide
);

    localparam logic [Wm-1:0] INF = '1;

    logic [Wm-1:0] bank_a_q [S];
    logic [Wm-1:0] bank_a_d [S];
    logic [Wm-1:0] bank_b_q [S];
    logic [Wm-1:0] bank_b_d [S];
    logic          prev_a_q, prev_a_d;
    logic [Wm-1:0] norm_off_q, norm_off_d;
    logic [Wm-1:0] run_min_q, run_min_d;
    logic [Wm-1:0] step_min_q, step_min_d;
    logic [15:0]   step_cnt_q, step_cnt_d;
    logic [S-1:0]  mask_q, mask_d;
    logic          err_inc_q, err_inc_d;
    logic          err_col_q, err_col_d;

    logic [Wm-1:0] cyc_min;
    logic [Wm-1:0] step_m;
    logic [S-1:0]  wr_mask;
    logic          collide;

    // INF stays INF; stale entries below the offset clamp to zero instead of wrapping.
    function automatic logic [Wm-1:0] norm_read(input logic [Wm-1:0] v, input logic [Wm-1:0] off);
        if (v == INF)
            return INF;
        else if (v < off)
            return '0;
        else
            return v - off;
    endfunction

    for (genvar j = 0; j < 2*P; j++) begin : g_rd
        logic [M-1:0]  ri;
        logic [Wm-1:0] v;
        assign ri = rd_idx[j*M +: M];
        assign v  = prev_a_q ? bank_a_q[ri] : bank_b_q[ri];
        assign rd_pm[j*Wm +: Wm] = norm_read(v, norm_off_q);
    end

    always_comb begin
        cyc_min = INF;
        wr_mask = '0;
        collide = 1'b0;
        for (int l = 0; l < P; l++) begin
            if (wr_en[l]) begin
                wr_mask[wr_idx[l*M +: M]] = 1'b1;
                if (wr_pm[l*Wm +: Wm] < cyc_min)
                    cyc_min = wr_pm[l*Wm +: Wm];
            end
            for (int l2 = l + 1; l2 < P; l2++) begin
                if (wr_en[l] && wr_en[l2] && (wr_idx[l*M +: M] == wr_idx[l2*M +: M]))
                    collide = 1'b1;
            end
        end
        step_m = (run_min_q < cyc_min) ? run_min_q : cyc_min;
    end

    always_comb begin
        bank_a_d   = bank_a_q;
        bank_b_d   = bank_b_q;
        prev_a_d   = prev_a_q;
        norm_off_d = norm_off_q;
        run_min_d  = run_min_q;
        step_min_d = step_min_q;
        step_cnt_d = step_cnt_q;
        mask_d     = mask_q;
        err_inc_d  = err_inc_q;
        err_col_d  = err_col_q;
        if (init_frame) begin
            for (int s = 0; s < S; s++) begin
                if (prev_a_q)
                    bank_a_d[s] = (init_mode || (M'(s) == init_state)) ? '0 : INF;
                else
                    bank_b_d[s] = (init_mode || (M'(s) == init_state)) ? '0 : INF;
            end
            norm_off_d = '0;
            run_min_d  = INF;
            step_min_d = INF;
            step_cnt_d = '0;
            mask_d     = '0;
            err_inc_d  = 1'b0;
            err_col_d  = 1'b0;
        end else begin
            // Ascending lane order lets the highest enabled lane win a shared index.
            for (int l = 0; l < P; l++) begin
                if (wr_en[l]) begin
                    if (prev_a_q)
                        bank_b_d[wr_idx[l*M +: M]] = wr_pm[l*Wm +: Wm];
                    else
                        bank_a_d[wr_idx[l*M +: M]] = wr_pm[l*Wm +: Wm];
                end
            end
            mask_d    = mask_q | wr_mask;
            run_min_d = step_m;
            if (collide)
                err_col_d = 1'b1;
            if (swap_banks) begin
                if (!(&(mask_q | wr_mask)))
                    err_inc_d = 1'b1;
                prev_a_d   = ~prev_a_q;
                step_min_d = step_m;
                norm_off_d = (norm_en && (step_m != INF)) ? step_m : '0;
                run_min_d  = INF;
                mask_d     = '0;
                step_cnt_d = step_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < S; s++) begin
                bank_a_q[s] <= '0;
                bank_b_q[s] <= '0;
            end
            prev_a_q   <= 1'b1;
            norm_off_q <= '0;
            run_min_q  <= INF;
            step_min_q <= INF;
            step_cnt_q <= '0;
            mask_q     <= '0;
            err_inc_q  <= 1'b0;
            err_col_q  <= 1'b0;
        end else begin
            for (int s = 0; s < S; s++) begin
                bank_a_q[s] <= bank_a_d[s];
                bank_b_q[s] <= bank_b_d[s];
            end
            prev_a_q   <= prev_a_d;
            norm_off_q <= norm_off_d;
            run_min_q  <= run_min_d;
            step_min_q <= step_min_d;
            step_cnt_q <= step_cnt_d;
            mask_q     <= mask_d;
            err_inc_q  <= err_inc_d;
            err_col_q  <= err_col_d;
        end
    end

    assign prev_A         = prev_a_q;
    assign step_min       = step_min_q;
    assign step_cnt       = step_cnt_q;
    assign err_incomplete = err_inc_q;
    assign err_collide    = err_col_q;

endmodule

// File: tb/tb_pm_bank_norm.sv
// tb/tb_pm_bank_norm.sv - directed and randomised checks for pm_bank_norm
// Directed steps use hand-computed values; the random phase uses an unnormalised reference model.
module tb_pm_bank_norm;

    localparam int M  = 4;
    localparam int S  = 16;
    localparam int P  = 2;
    localparam int Wm = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_frame = 1'b0;
    logic              init_mode = 1'b0;
    logic [M-1:0]      init_state = '0;
    logic              norm_en = 1'b0;
    logic [2*P*M-1:0]  rd_idx = '0;
    logic [2*P*Wm-1:0] rd_pm;
    logic [P-1:0]      wr_en = '0;
    logic [P*M-1:0]    wr_idx = '0;
    logic [P*Wm-1:0]   wr_pm = '0;
    logic              swap_banks = 1'b0;
    logic              prev_A;
    logic [Wm-1:0]     step_min;
    logic [15:0]       step_cnt;
    logic              err_incomplete;
    logic              err_collide;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  mbank [2][S];
    logic        m_prev_a;
    logic [7:0]  m_off, m_run, m_smin;
    logic [15:0] m_cnt, m_mask;
    logic        m_einc, m_ecol;

    pm_bank_norm #(.K(5), .P(P), .Wm(Wm)) dut (
        .clk(clk), .rst_n(rst_n), .init_frame(init_frame), .init_mode(init_mode),
        .init_state(init_state), .norm_en(norm_en), .rd_idx(rd_idx), .rd_pm(rd_pm),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_pm(wr_pm), .swap_banks(swap_banks),
        .prev_A(prev_A), .step_min(step_min), .step_cnt(step_cnt),
        .err_incomplete(err_incomplete), .err_collide(err_collide)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic rd(input int idx, output logic [7:0] v);
        rd_idx[3:0] = 4'(idx);
        #1;
        v = rd_pm[7:0];
    endtask

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            mbank[0][s] = 8'd0;
            mbank[1][s] = 8'd0;
        end
        m_prev_a = 1'b1; m_off = 8'd0; m_run = 8'd255; m_smin = 8'd255;
        m_cnt = 16'd0; m_mask = 16'd0; m_einc = 1'b0; m_ecol = 1'b0;
    endtask

    // Advance the reference model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        int prv, cur;
        logic [7:0] cmin;
        logic [3:0] ix;
        prv = m_prev_a ? 0 : 1;
        cur = 1 - prv;
        if (init_frame) begin
            for (int s = 0; s < S; s++)
                mbank[prv][s] = (init_mode || (s == int'(init_state))) ? 8'd0 : 8'd255;
            m_off = 8'd0; m_run = 8'd255; m_smin = 8'd255; m_cnt = 16'd0;
            m_mask = 16'd0; m_einc = 1'b0; m_ecol = 1'b0;
        end else begin
            cmin = m_run;
            for (int l = 0; l < P; l++) begin
                if (wr_en[l]) begin
                    ix = wr_idx[l*M +: M];
                    mbank[cur][ix] = wr_pm[l*Wm +: Wm];
                    m_mask[ix] = 1'b1;
                    if (wr_pm[l*Wm +: Wm] < cmin) cmin = wr_pm[l*Wm +: Wm];
                end
            end
            if (wr_en == 2'b11 && wr_idx[3:0] == wr_idx[7:4]) m_ecol = 1'b1;
            m_run = cmin;
            if (swap_banks) begin
                if (m_mask != 16'hffff) m_einc = 1'b1;
                m_smin = cmin;
                m_off = (norm_en && cmin != 8'd255) ? cmin : 8'd0;
                m_run = 8'd255; m_mask = 16'd0; m_cnt = m_cnt + 16'd1;
                m_prev_a = ~m_prev_a;
            end
        end
        @(posedge clk);
        #1;
        wr_en = '0; swap_banks = 1'b0; init_frame = 1'b0;
    endtask

    task automatic wr2(input int i0, input int p0, input int i1, input int p1,
                       input logic [1:0] en, input logic sw);
        wr_idx = {4'(i1), 4'(i0)};
        wr_pm  = {8'(p1), 8'(p0)};
        wr_en  = en;
        swap_banks = sw;
        tick();
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] raw, exp;
        logic [3:0] ri;
        int bad;

        model_reset();
        #12;
        rst_n = 1'b1;
        chk("reset_prev_A", prev_A, 1);
        chk("reset_step_min", step_min, 255);
        chk("reset_step_cnt", step_cnt, 0);
        chk("reset_err_inc", err_incomplete, 0);
        chk("reset_err_col", err_collide, 0);
        rd(9, v); chk("reset_rd", v, 0);

        // Known start state 3
        init_frame = 1'b1; init_mode = 1'b0; init_state = 4'd3;
        tick();
        bad = 0;
        for (int s = 0; s < S; s++) begin
            rd(s, v);
            if (s != 3 && v != 8'd255) bad++;
        end
        chk("init0_others_inf", bad, 0);
        rd(3, v); chk("init0_idx3", v, 0);
        chk("init0_prev_A", prev_A, 1);

        // Full step pm=10+idx, normalised
        norm_en = 1'b1;
        for (int c = 0; c < 8; c++)
            wr2(2*c, 10 + 2*c, 2*c + 1, 11 + 2*c, 2'b11, c == 7);
        chk("s1_step_min", step_min, 10);
        chk("s1_prev_A", prev_A, 0);
        rd(5, v); chk("s1_rd5", v, 5);
        rd(0, v); chk("s1_rd0", v, 0);
        chk("s1_err_inc", err_incomplete, 0);
        chk("s1_step_cnt", step_cnt, 1);

        // Incomplete step: idx3 left stale at 0, offset 50
        for (int c = 0; c < 8; c++)
            wr2(2*c, 50 + 2*c, 2*c + 1, 51 + 2*c, (c == 1) ? 2'b01 : 2'b11, c == 7);
        chk("s2_err_inc", err_incomplete, 1);
        chk("s2_step_min", step_min, 50);
        rd(3, v); chk("s2_stale_clamp", v, 0);
        rd(4, v); chk("s2_rd4", v, 4);
        chk("s2_step_cnt", step_cnt, 2);

        norm_en = 1'b0;
        for (int c = 0; c < 8; c++)
            wr2(2*c, 100 + 2*c, 2*c + 1, 101 + 2*c, 2'b11, c == 7);
        chk("s3_err_inc_sticky", err_incomplete, 1);
        rd(2, v); chk("s3_rd2_raw", v, 102);
        chk("s3_step_min", step_min, 100);
        chk("s3_prev_A", prev_A, 0);

        // Collision on idx 7: lane 1 wins
        wr2(7, 20, 7, 30, 2'b11, 1'b1);
        chk("col_err", err_collide, 1);
        rd(7, v); chk("col_rd7", v, 30);
        chk("col_step_min", step_min, 20);
        chk("col_step_cnt", step_cnt, 4);
        chk("col_prev_A", prev_A, 1);

        // init_frame overrides same-cycle writes and swap
        init_frame = 1'b1; init_mode = 1'b1;
        wr2(7, 99, 8, 98, 2'b11, 1'b1);
        chk("init1_prev_A", prev_A, 1);
        rd(7, v); chk("init1_rd7", v, 0);
        rd(15, v); chk("init1_rd15", v, 0);
        chk("init1_err_inc", err_incomplete, 0);
        chk("init1_err_col", err_collide, 0);
        chk("init1_step_cnt", step_cnt, 0);
        chk("init1_step_min", step_min, 255);
        norm_en = 1'b1;
        wr2(0, 0, 0, 0, 2'b00, 1'b1);
        rd(7, v); chk("drop_rd7", v, 107);
        rd(8, v); chk("drop_rd8", v, 108);
        chk("empty_step_min", step_min, 255);
        chk("empty_err_inc", err_incomplete, 1);

        // Asynchronous reset mid-step
        wr2(1, 5, 2, 6, 2'b11, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_prev_A", prev_A, 1);
        chk("midrst_step_min", step_min, 255);
        chk("midrst_step_cnt", step_cnt, 0);
        chk("midrst_err_inc", err_incomplete, 0);
        chk("midrst_err_col", err_collide, 0);
        chk("midrst_rd", rd_pm[7:0], 0);
        model_reset();
        rst_n = 1'b1;

        for (int st = 0; st < 1000; st++) begin
            norm_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < 8; c++) begin
                rd_idx = 16'($urandom);
                #1;
                for (int j = 0; j < 2*P; j++) begin
                    ri  = rd_idx[j*M +: M];
                    raw = mbank[m_prev_a ? 0 : 1][ri];
                    exp = (raw == 8'd255) ? 8'd255 : ((raw < m_off) ? 8'd0 : raw - m_off);
                    chk($sformatf("rnd_rd_s%0d_l%0d", st, j), rd_pm[j*Wm +: Wm], exp);
                end
                init_frame = ($urandom_range(0, 399) == 0);
                init_mode  = 1'($urandom_range(0, 1));
                init_state = 4'($urandom);
                wr_en  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
                wr_idx = {4'(2*c + 1), 4'(2*c)};
                if ($urandom_range(0, 31) == 0) wr_idx[7:4] = wr_idx[3:0];
                wr_pm  = 16'($urandom);
                swap_banks = (c == 7);
                tick();
            end
            chk($sformatf("rnd_prev_A_s%0d", st), prev_A, m_prev_a);
            chk($sformatf("rnd_step_min_s%0d", st), step_min, m_smin);
            chk($sformatf("rnd_step_cnt_s%0d", st), step_cnt, m_cnt);
            chk($sformatf("rnd_err_inc_s%0d", st), err_incomplete, m_einc);
            chk($sformatf("rnd_err_col_s%0d", st), err_collide, m_ecol);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
